// File: rtl/video_if.sv
// Raster video stream bundle: the source drives timing and pixel data,
// the sink supplies the enable that advances the raster.
interface video_if;
  logic        enable;
  logic        de_out;
  logic        h_sync_out;
  logic        v_sync_out;
  logic [23:0] pixel_out;
  logic        frame_done;

  modport master (
    input  enable,
    output de_out, h_sync_out, v_sync_out, pixel_out, frame_done
  );

  modport slave (
    output enable,
    input  de_out, h_sync_out, v_sync_out, pixel_out, frame_done
  );
endinterface

// File: rtl/video_frame_gen.sv
// Raster timing and one-square test image source for the vision pipeline.
// Define VFG_MOTION_EN to make the square bounce around the active area.
module video_frame_gen #(
  parameter int          IMG_W     = 64,
  parameter int          IMG_H     = 64,
  parameter int          H_FP      = 4,
  parameter int          H_SYNC    = 8,
  parameter int          H_BP      = 4,
  parameter int          V_FP      = 2,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 2,
  parameter int          OBJ_SIZE  = 8,
  parameter int          OBJ_X0    = 10,
  parameter int          OBJ_Y0    = 20,
  parameter logic [23:0] OBJ_COLOR = 24'hE0A080
) (
  input logic      clk,
  input logic      rst,
  video_if.master  vid
);
  localparam int H_TOTAL = IMG_W + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = IMG_H + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] W_C    = 11'(IMG_W);
  localparam logic [10:0] H_C    = 11'(IMG_H);
  localparam logic [10:0] HS_BEG = 11'(IMG_W + H_FP);
  localparam logic [10:0] HS_END = 11'(IMG_W + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(IMG_H + V_FP);
  localparam logic [10:0] VS_END = 11'(IMG_H + V_FP + V_SYNC);
  localparam logic [10:0] SIZE_C = 11'(OBJ_SIZE);

  if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_chk_total
    $error("video_frame_gen: H_TOTAL/V_TOTAL must not exceed 2047");
  end
  if (OBJ_SIZE < 1 || OBJ_SIZE >= IMG_W || OBJ_SIZE >= IMG_H ||
      OBJ_X0 < 0 || OBJ_X0 > IMG_W - OBJ_SIZE ||
      OBJ_Y0 < 0 || OBJ_Y0 > IMG_H - OBJ_SIZE) begin : g_chk_obj
    $error("video_frame_gen: object must fit inside the active area");
  end

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [10:0] obj_x;
  logic [10:0] obj_y;
  logic        line_end;
  logic        frame_end;
  logic        de;
  logic        hs;
  logic        vs;
  logic        in_obj;

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (vid.enable) begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  assign de     = (h_cnt < W_C) && (v_cnt < H_C);
  assign hs     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign in_obj = (h_cnt >= obj_x) && (h_cnt < obj_x + SIZE_C) &&
                  (v_cnt >= obj_y) && (v_cnt < obj_y + SIZE_C);

  // Outputs present the position held before the edge, so they trail the
  // counters by one enabled clock and simply hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vid.de_out     <= 1'b0;
      vid.h_sync_out <= 1'b0;
      vid.v_sync_out <= 1'b0;
      vid.pixel_out  <= 24'h0;
      vid.frame_done <= 1'b0;
    end else if (vid.enable) begin
      vid.de_out     <= de;
      vid.h_sync_out <= hs;
      vid.v_sync_out <= vs;
      vid.pixel_out  <= (de && in_obj) ? OBJ_COLOR : 24'h0;
      vid.frame_done <= frame_end;
    end
  end

`ifdef VFG_MOTION_EN
  localparam logic [10:0] X_MAX = 11'(IMG_W - OBJ_SIZE);
  localparam logic [10:0] Y_MAX = 11'(IMG_H - OBJ_SIZE);

  logic dx_neg;
  logic dy_neg;

  // Returns {direction_negative, position} after one bounce-aware step.
  function automatic logic [11:0] bounce(input logic [10:0] pos,
                                         input logic        neg,
                                         input logic [10:0] lim);
    if (!neg)
      return (pos == lim)   ? {1'b1, pos - 11'd1} : {1'b0, pos + 11'd1};
    else
      return (pos == 11'd0) ? {1'b0, pos + 11'd1} : {1'b1, pos - 11'd1};
  endfunction

  // Updating only on the frame wrap keeps the square whole within a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      obj_x  <= 11'(OBJ_X0);
      obj_y  <= 11'(OBJ_Y0);
      dx_neg <= 1'b0;
      dy_neg <= 1'b0;
    end else if (vid.enable && frame_end) begin
      {dx_neg, obj_x} <= bounce(obj_x, dx_neg, X_MAX);
      {dy_neg, obj_y} <= bounce(obj_y, dy_neg, Y_MAX);
    end
  end
`else
  assign obj_x = 11'(OBJ_X0);
  assign obj_y = 11'(OBJ_Y0);
`endif

endmodule

// File: tb/tb_video_frame_gen.sv
// Scoreboard bench for video_frame_gen: a default-size instance and a small
// instance (fast frames, frequent bounces) share one rst/enable stimulus.
module tb_video_frame_gen;
  localparam int S_W = 12, S_H = 10, S_HFP = 1, S_HS = 2, S_HBP = 1;
  localparam int S_VFP = 1, S_VS = 1, S_VBP = 1, S_SZ = 3, S_X0 = 2, S_Y0 = 5;
  localparam logic [23:0] S_COL = 24'h123456;

  typedef struct {
    int w, h, hfp, hsync, hbp, vfp, vsync, vbp, sz, x0, y0;
    logic [23:0] col;
  } cfg_t;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fd;
    logic [23:0] px;
  } out_t;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  bit   done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cfg_t cfg [2];
  int   pos [2];
  int   frame [2];
  out_t last [2];
  out_t q_d [$];
  out_t q_s [$];

  always #5 clk = ~clk;

  video_if vi_d ();
  video_if vi_s ();
  assign vi_d.enable = enable;
  assign vi_s.enable = enable;

  video_frame_gen dut_d (.clk(clk), .rst(rst), .vid(vi_d));

  video_frame_gen #(
    .IMG_W(S_W), .IMG_H(S_H), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .OBJ_SIZE(S_SZ),
    .OBJ_X0(S_X0), .OBJ_Y0(S_Y0), .OBJ_COLOR(S_COL)
  ) dut_s (.clk(clk), .rst(rst), .vid(vi_s));

  task automatic check(string name, logic [27:0] got, logic [27:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  function automatic int htot(cfg_t c);
    return c.w + c.hfp + c.hsync + c.hbp;
  endfunction

  function automatic int vtot(cfg_t c);
    return c.h + c.vfp + c.vsync + c.vbp;
  endfunction

  // Object coordinate in frame f: a triangle wave over [0, lim] starting at
  // 'start' moving upward, i.e. bouncing without repeating the boundary.
  function automatic int obj_coord(int start, int lim, int f);
`ifdef VFG_MOTION_EN
    int t;
    t = (start + f) % (2 * lim);
    return (t <= lim) ? t : 2 * lim - t;
`else
    return start + 0 * lim * f;
`endif
  endfunction

  function automatic out_t model_out(cfg_t c, int p, int f);
    int   x, y, ox, oy;
    out_t o;
    x  = p % htot(c);
    y  = p / htot(c);
    ox = obj_coord(c.x0, c.w - c.sz, f);
    oy = obj_coord(c.y0, c.h - c.sz, f);
    o.de = (x < c.w) && (y < c.h);
    o.hs = (x >= c.w + c.hfp) && (x < c.w + c.hfp + c.hsync);
    o.vs = (y >= c.h + c.vfp) && (y < c.h + c.vfp + c.vsync);
    o.fd = (p == htot(c) * vtot(c) - 1);
    o.px = (o.de && x >= ox && x < ox + c.sz && y >= oy && y < oy + c.sz)
           ? c.col : 24'h0;
    return o;
  endfunction

  // Predict what each DUT presents after the coming edge and queue it.
  task automatic model_push();
    for (int i = 0; i < 2; i++) begin
      out_t e;
      if (rst) begin
        e        = '0;
        pos[i]   = 0;
        frame[i] = 0;
      end else if (enable) begin
        e = model_out(cfg[i], pos[i], frame[i]);
        pos[i]++;
        if (pos[i] == htot(cfg[i]) * vtot(cfg[i])) begin
          pos[i] = 0;
          frame[i]++;
        end
      end else begin
        e = last[i];
      end
      last[i] = e;
      if (i == 0) q_d.push_back(e);
      else        q_s.push_back(e);
    end
  endtask

  task automatic apply(input logic r, input logic e);
    rst    = r;
    enable = e;
    model_push();
  endtask

  task automatic step(input logic r, input logic e);
    @(negedge clk);
    apply(r, e);
  endtask

  // Monitors: compare every presented output against the scoreboard head.
  out_t got_d, exp_d, got_s, exp_s;

  always @(posedge clk) begin
    #1;
    if (!done) begin
      got_d = {vi_d.de_out, vi_d.h_sync_out, vi_d.v_sync_out, vi_d.frame_done,
               vi_d.pixel_out};
      if (q_d.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dflt_underflow t=%0t got=%h expected=queued entry", $time, got_d);
      end else begin
        exp_d = q_d.pop_front();
        check("dflt_out", got_d, exp_d);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!done) begin
      got_s = {vi_s.de_out, vi_s.h_sync_out, vi_s.v_sync_out, vi_s.frame_done,
               vi_s.pixel_out};
      if (q_s.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL small_underflow t=%0t got=%h expected=queued entry", $time, got_s);
      end else begin
        exp_s = q_s.pop_front();
        check("small_out", got_s, exp_s);
      end
    end
  end

  initial begin
    cfg[0] = '{w: 64, h: 64, hfp: 4, hsync: 8, hbp: 4, vfp: 2, vsync: 2,
               vbp: 2, sz: 8, x0: 10, y0: 20, col: 24'hE0A080};
    cfg[1] = '{w: S_W, h: S_H, hfp: S_HFP, hsync: S_HS, hbp: S_HBP,
               vfp: S_VFP, vsync: S_VS, vbp: S_VBP, sz: S_SZ, x0: S_X0,
               y0: S_Y0, col: S_COL};
    for (int i = 0; i < 2; i++) begin
      pos[i]   = 0;
      frame[i] = 0;
      last[i]  = '0;
    end

    // Reset held for 10 clocks with enable high.
    apply(1'b1, 1'b1);
    repeat (9) step(1'b1, 1'b1);

    // Full frame 0, then into frame 1 up to line 30, x=20.
    while (!(frame[0] == 1 && pos[0] == 30 * htot(cfg[0]) + 20)) step(1'b0, 1'b1);

    // Mid-line stall: outputs must hold for all 50 clocks.
    repeat (50) step(1'b0, 1'b0);

    // Run to line 30 of frame 2 and pulse reset there.
    while (!(frame[0] == 2 && pos[0] == 30 * htot(cfg[0]))) step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    // Randomly gated enable: the small instance bounces on both axes.
    repeat (14000) step(1'b0, 1'($urandom_range(0, 9) != 0));

    @(posedge clk);
    #2;
    done = 1'b1;
    check("dflt_drain", 28'(q_d.size()), 28'd0);
    check("small_drain", 28'(q_s.size()), 28'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
